// File: rtl/dynamic_adder_pkg.sv
// ============================================================================
// Package : dynamic_adder_pkg
// Purpose : FSM state type and segment-count helpers for iter_drca.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dynamic_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_N = 8;
  localparam int DEFAULT_W = 4;

  function automatic int seg_count(input int n, input int w);
    return n / w;
  endfunction

  // Wide enough to hold K itself, not just K-1.
  function automatic int lat_width(input int n, input int w);
    return $clog2(n / w) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_rca.sv
// ============================================================================
// Module  : seg_rca
// Purpose : W-bit combinational ripple-carry adder segment.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar i = 0; i < W; i++) begin : g_bit
      assign s[i]      = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = w_c[W];

endmodule

`default_nettype wire

// File: rtl/iter_drca.sv
// ============================================================================
// Module  : iter_drca
// Purpose : Iterative adder, one W-bit segment per cycle through a shared
//           seg_rca. Optional early completion via ITER_DRCA_EARLY_DONE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iter_drca
  import dynamic_adder_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 A,
  input  logic [N-1:0]                 B,
  input  logic                         Cin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 S,
  output logic [N-1:0]                 P,
  output logic                         Cout,
  output logic [lat_width(N, W)-1:0]   lat
);

  localparam int K  = seg_count(N, W);
  localparam int LW = lat_width(N, W);

  generate
    if ((N % W) != 0 || N < W) begin : g_cfg_check
      $error("iter_drca: N must be a non-zero multiple of W");
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_nxt;

  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_carry;
  logic [LW-1:0]   r_idx;
  logic [N-1:0]    r_s;
  logic [N-1:0]    r_p;
  logic            r_cout;
  logic [LW-1:0]   r_lat;

  logic [W-1:0]    w_seg_a;
  logic [W-1:0]    w_seg_b;
  logic [W-1:0]    w_seg_s;
  logic            w_seg_cout;
  logic            w_last;
  logic            w_early;
  logic            w_accept;
  logic            w_finish;

  assign w_seg_a  = r_a[int'(r_idx)*W +: W];
  assign w_seg_b  = r_b[int'(r_idx)*W +: W];
  assign w_last   = (r_idx == LW'(K - 1));

  seg_rca #(
    .W    (W)
  ) u_seg_rca (
    .a    (w_seg_a),
    .b    (w_seg_b),
    .cin  (r_carry),
    .s    (w_seg_s),
    .cout (w_seg_cout)
  );

`ifdef ITER_DRCA_EARLY_DONE_EN
  // Nothing left to add above this segment and no carry to ripple: the
  // remaining S slices are already zero from acceptance, so stop here.
  logic [N-1:0] w_hi_bits;
  assign w_hi_bits = (r_a | r_b) >> (W * (int'(r_idx) + 1));
  assign w_early   = !w_last && !w_seg_cout && (w_hi_bits == '0);
`else
  assign w_early   = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_finish = (r_state == BUSY) && (w_last || w_early);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = BUSY;
      BUSY:    if (w_finish)  w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand and result datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_p     <= '0;
      r_cout  <= 1'b0;
      r_lat   <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_carry <= Cin;
      r_idx   <= '0;
      r_p     <= A ^ B;
      r_s     <= '0;
    end else if (r_state == BUSY) begin
      r_s[int'(r_idx)*W +: W] <= w_seg_s;
      r_carry                 <= w_seg_cout;
      r_idx                   <= r_idx + LW'(1);
      if (w_finish) begin
        r_cout <= w_seg_cout;
        r_lat  <= r_idx + LW'(1);
      end
    end
  end

  assign S    = r_s;
  assign P    = r_p;
  assign Cout = r_cout;
  assign lat  = r_lat;

endmodule

`default_nettype wire

// File: tb/tb_iter_drca.sv
// ============================================================================
// Module  : tb_iter_drca
// Purpose : Directed self-checking bench for iter_drca (N=8/W=4 and N=16/W=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iter_drca;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready, out_valid, cout8;
  logic [7:0]  s8, p8;
  logic [1:0]  lat8;

  logic        in_valid_w = 1'b0, out_ready_w = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready_w, out_valid_w, cout16;
  logic [15:0] s16, p16;
  logic [2:0]  lat16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iter_drca #(.N(8), .W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a8), .B(b8), .Cin(cin8), .out_valid(out_valid), .out_ready(out_ready),
    .S(s8), .P(p8), .Cout(cout8), .lat(lat8)
  );

  iter_drca #(.N(16), .W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .A(a16), .B(b16), .Cin(cin16), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .S(s16), .P(p16), .Cout(cout16), .lat(lat16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [4:0] lo;
    lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c};
`ifdef ITER_DRCA_EARLY_DONE_EN
    if (!lo[4] && a[7:4] == 4'h0 && b[7:4] == 4'h0) return 1;
`endif
    return (lo[4] === 1'bx) ? 2 : 2;
  endfunction

  // One full operation on the 8-bit instance; rnd_ready randomises out_ready.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input string tag, input bit rnd_ready);
    int t;
    int cyc;
    int el;
    logic [8:0] sum;
    t = 0;
    while (!in_ready && t < 50) begin
      if (rnd_ready) out_ready = 1'b1;
      step();
      t++;
    end
    chk({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    a8 = a; b8 = b; cin8 = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a8 = $urandom; b8 = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      cyc++;
    end
    el  = exp_lat8(a, b, c);
    sum = {1'b0, a} + {1'b0, b} + {8'b0, c};
    chk({tag, "_cycles"}, 32'(cyc), 32'(el));
    chk({tag, "_S"}, 32'(s8), 32'(sum[7:0]));
    chk({tag, "_P"}, 32'(p8), 32'(a ^ b));
    chk({tag, "_Cout"}, 32'(cout8), 32'(sum[8]));
    chk({tag, "_lat"}, 32'(lat8), 32'(el));
    if (!rnd_ready) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
      chk({tag, "_iready_set"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int cyc;
    logic [7:0] ra, rb;
    logic       rc;

    // Reset state
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_S", 32'(s8), 32'd0);
    chk("rst_P", 32'(p8), 32'd0);
    chk("rst_Cout", 32'(cout8), 32'd0);
    chk("rst_lat", 32'(lat8), 32'd0);
    chk("rst16_lat", 32'(lat16), 32'd0);
    rst = 1'b0;
    step();

    // Carry ripples across both segments
    run8(8'hFF, 8'h01, 1'b0, "ff_plus_1", 1'b0);

    // Small operands: early completion only when the feature is built in
    run8(8'h01, 8'h02, 1'b0, "small", 1'b0);

    // Backpressure in DONE
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    chk("bp_cycles", 32'(cyc), 32'd2);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_S", 32'(s8), 32'h97);
      chk("bp_P", 32'(p8), 32'h66);
      chk("bp_Cout", 32'(cout8), 32'd0);
      chk("bp_lat", 32'(lat8), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_ovalid", 32'(out_valid), 32'd0);
    step();
    chk("idle_retain_S", 32'(s8), 32'h97);
    chk("idle_retain_P", 32'(p8), 32'h66);
    chk("idle_retain_lat", 32'(lat8), 32'd2);

    // Reset one cycle into BUSY
    a8 = 8'h77; b8 = 8'h88; cin8 = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_S", 32'(s8), 32'd0);
    chk("midrst_P", 32'(p8), 32'd0);
    chk("midrst_Cout", 32'(cout8), 32'd0);
    chk("midrst_lat", 32'(lat8), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_ovalid", 32'(out_valid), 32'd0);
    end
    run8(8'h12, 8'h34, 1'b0, "after_rst", 1'b0);

    // 16-bit instance: carry through all four segments
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; in_valid_w = 1'b1;
    step();
    in_valid_w = 1'b0;
    cyc = 0;
    while (!out_valid_w && cyc < 20) begin step(); cyc++; end
    chk("w16_cycles", 32'(cyc), 32'd4);
    chk("w16_S", 32'(s16), 32'h0000);
    chk("w16_P", 32'(p16), 32'hFFFF);
    chk("w16_Cout", 32'(cout16), 32'd1);
    chk("w16_lat", 32'(lat16), 32'd4);
    out_ready_w = 1'b1;
    step();
    out_ready_w = 1'b0;
    chk("w16_idle", 32'(in_ready_w), 32'd1);

    // Random back-to-back traffic with random out_ready
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      if (i % 4 == 0) ra = 8'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      run8(ra, rb, rc, "rand", 1'b1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
